// File: rtl/sobel_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, the frame memories and the filter.
// master: the sequencer; slave: the memories, filter and frame control around it.
interface sobel_frame_sequencer_if #(
   parameter int PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH  = 16
);
   logic                   start;
   logic                   pause;
   logic                   busy;
   logic                   done;
   logic                   error;
   logic                   rd_en;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [PIXEL_WIDTH-1:0] rd_data;
   logic                   flt_rst_n;
   logic [PIXEL_WIDTH-1:0] flt_pixel;
   logic                   flt_valid;
   logic [PIXEL_WIDTH-1:0] flt_edge;
   logic                   flt_valid_out;
   logic                   wr_en;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [PIXEL_WIDTH-1:0] wr_data;

   modport master (
      input  start, pause, rd_data, flt_edge, flt_valid_out,
      output busy, done, error, rd_en, rd_addr, flt_rst_n, flt_pixel, flt_valid,
             wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, pause, rd_data, flt_edge, flt_valid_out,
      input  busy, done, error, rd_en, rd_addr, flt_rst_n, flt_pixel, flt_valid,
             wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Sequences one frame: clears the filter, streams the source frame in raster order, stores filter results.
// Optional drain watchdog enabled by defining SOBEL_SEQ_TIMEOUT_EN.
module sobel_frame_sequencer #(
   parameter int PIXEL_WIDTH   = 8,
   parameter int IMAGE_WIDTH   = 8,
   parameter int IMAGE_HEIGHT  = 8,
   parameter int OUT_PIXELS    = (IMAGE_WIDTH - 2) * (IMAGE_HEIGHT - 2),
   parameter int ADDR_WIDTH    = 16,
   parameter int CLEAR_CYCLES  = 2,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   sobel_frame_sequencer_if.master bus
);

   localparam int N_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int CLR_W    = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_RD  = ADDR_WIDTH'(N_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WR  = ADDR_WIDTH'(OUT_PIXELS - 1);

   if (CLEAR_CYCLES < 1) begin : g_chk_clear
      $error("CLEAR_CYCLES must be at least 1");
   end
   if (DRAIN_TIMEOUT < 1) begin : g_chk_timeout
      $error("DRAIN_TIMEOUT must be at least 1");
   end
   if (OUT_PIXELS < 1) begin : g_chk_out
      $error("OUT_PIXELS must be at least 1");
   end
   if (longint'(N_PIXELS) > (64'd1 << ADDR_WIDTH) ||
       longint'(OUT_PIXELS) > (64'd1 << ADDR_WIDTH)) begin : g_chk_addr
      $error("frame does not fit in ADDR_WIDTH address space");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [CLR_W-1:0]       clr_cnt;
   logic [ADDR_WIDTH-1:0]  rd_cnt;
   logic [ADDR_WIDTH-1:0]  wr_cnt;
   logic                   start_acc;
   logic                   rd_en_p0;
   logic                   vld_p1;
   logic                   capture_p0;
   logic                   wr_vld_p1;
   logic [ADDR_WIDTH-1:0]  wr_addr_p1;
   logic [PIXEL_WIDTH-1:0] wr_data_p1;
   logic                   last_wr;
   logic                   timeout;
   logic                   in_frame;

   assign start_acc = (state_q == S_IDLE) && bus.start;
   assign in_frame  = (state_q == S_FEED) || (state_q == S_DRAIN);
   // The final result write ends the frame; anything the filter offers in that cycle is surplus.
   assign last_wr    = wr_vld_p1 && (wr_addr_p1 == LAST_WR);
   assign capture_p0 = in_frame && bus.flt_valid_out && !last_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_en_p0 = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (clr_cnt == CLR_LAST) state_d = S_FEED;
         end
         S_FEED: begin
            rd_en_p0 = !bus.pause;
            if (last_wr) begin
               state_d = S_DONE;
            end else if (rd_en_p0 && (rd_cnt == LAST_RD)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_wr || timeout) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
      end else if (start_acc) begin
         clr_cnt <= '0;
         rd_cnt  <= '0;
         wr_cnt  <= '0;
      end else begin
         if (state_q == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (rd_en_p0)           rd_cnt  <= rd_cnt + 1'b1;
         if (capture_p0)         wr_cnt  <= wr_cnt + 1'b1;
      end
   end

   // p0 -> p1: read strobe becomes filter valid; accepted filter output becomes a result write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         wr_vld_p1  <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1    <= rd_en_p0;
         wr_vld_p1 <= capture_p0;
         if (capture_p0) begin
            wr_addr_p1 <= wr_cnt;
            wr_data_p1 <= bus.flt_edge;
         end
      end
   end

`ifdef SOBEL_SEQ_TIMEOUT_EN
   localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              error_q;

   // Fires on the last of DRAIN_TIMEOUT consecutive DRAIN cycles without a filter output.
   assign timeout = (state_q == S_DRAIN) && !bus.flt_valid_out && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         if ((state_q != S_DRAIN) || bus.flt_valid_out) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
         if (start_acc) begin
            error_q <= 1'b0;
         end else if (timeout && !last_wr) begin
            error_q <= 1'b1;
         end
      end
   end

   assign bus.error = error_q;
`else
   assign timeout   = 1'b0;
   assign bus.error = 1'b0;
`endif

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.flt_rst_n = (state_q != S_CLEAR);
   assign bus.rd_en     = rd_en_p0;
   assign bus.rd_addr   = rd_cnt;
   assign bus.flt_valid = vld_p1;
   assign bus.flt_pixel = vld_p1 ? bus.rd_data : '0;
   assign bus.wr_en     = wr_vld_p1;
   assign bus.wr_addr   = wr_addr_p1;
   assign bus.wr_data   = wr_data_p1;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with a source memory and a simple 3x3-window filter model.
module tb_sobel_frame_sequencer;

   localparam int PW   = 8;
   localparam int IW   = 8;
   localparam int IH   = 8;
   localparam int N    = IW * IH;
   localparam int OUTP = (IW - 2) * (IH - 2);
   localparam int AW   = 16;
   localparam int CLR  = 2;
   localparam int DTO  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sobel_frame_sequencer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus ();

   sobel_frame_sequencer #(
      .PIXEL_WIDTH  (PW),
      .IMAGE_WIDTH  (IW),
      .IMAGE_HEIGHT (IH),
      .ADDR_WIDTH   (AW),
      .CLEAR_CYCLES (CLR),
      .DRAIN_TIMEOUT(DTO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic logic [7:0] pix(input int a);
      return 8'((a * 7 + 3) & 255);
   endfunction

   // Result i comes from the i-th pixel whose 3x3 window is complete (row >= 2, col >= 2).
   function automatic int exp_edge(input int i);
      int a;
      a = (2 + i / (IW - 2)) * IW + 2 + i % (IW - 2);
      return int'(pix(a) ^ 8'h5A);
   endfunction

   // source frame memory: one-cycle read latency
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= pix(int'(bus.rd_addr));
   end

   // filter model
   int         pcnt;
   int         m_emit;
   int         m_limit = OUTP;
   logic       mdl_vld;
   logic [7:0] mdl_edge;
   logic       spur = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst || !bus.flt_rst_n) begin
         pcnt     <= 0;
         m_emit   <= 0;
         mdl_vld  <= 1'b0;
         mdl_edge <= 8'h00;
      end else if (bus.flt_valid) begin
         if ((pcnt / IW) >= 2 && (pcnt % IW) >= 2 && m_emit < m_limit) begin
            mdl_vld  <= 1'b1;
            mdl_edge <= bus.flt_pixel ^ 8'h5A;
            m_emit   <= m_emit + 1;
         end else begin
            mdl_vld <= 1'b0;
         end
         pcnt <= pcnt + 1;
      end else begin
         mdl_vld <= 1'b0;
      end
   end

   assign bus.flt_valid_out = mdl_vld | spur;
   assign bus.flt_edge      = spur ? 8'hEE : mdl_edge;

   // event logs
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_addr_log[$];
   int rd_cyc_log[$];
   int fv_cyc_log[$];
   int vo_cyc_log[$];
   int wr_addr_log[$];
   int wr_data_log[$];
   int wr_cyc_log[$];
   int done_cyc_log[$];
   int clr_low_n = 0;

   always @(negedge clk) begin
      if (bus.rd_en === 1'b1) begin
         rd_addr_log.push_back(int'(bus.rd_addr));
         rd_cyc_log.push_back(cyc);
      end
      if (bus.flt_valid === 1'b1) fv_cyc_log.push_back(cyc);
      if (bus.flt_valid_out === 1'b1) vo_cyc_log.push_back(cyc);
      if (bus.wr_en === 1'b1) begin
         wr_addr_log.push_back(int'(bus.wr_addr));
         wr_data_log.push_back(int'(bus.wr_data));
         wr_cyc_log.push_back(cyc);
      end
      if (bus.done === 1'b1) done_cyc_log.push_back(cyc);
      if (bus.flt_rst_n === 1'b0) clr_low_n <= clr_low_n + 1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int target);
      int k;
      k = 0;
      while (done_cyc_log.size() < target && k < 2000) begin
         step();
         k++;
      end
      chk(tag, done_cyc_log.size(), target);
   endtask

   task automatic check_frame(input string tag, input int rb, input int wb, input int nout);
      int bad_r;
      int bad_w;
      bad_r = 0;
      bad_w = 0;
      for (int k = 0; k < N; k++) begin
         if (rb + k >= rd_addr_log.size() || rd_addr_log[rb + k] != k) bad_r++;
      end
      chk({tag, "_rd_addr_errs"}, bad_r, 0);
      for (int i = 0; i < nout; i++) begin
         if (wb + i >= wr_addr_log.size() || wr_addr_log[wb + i] != i ||
             wr_data_log[wb + i] != exp_edge(i)) bad_w++;
      end
      chk({tag, "_wr_errs"}, bad_w, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int rb, wb, fb, db, clb, wn, k;
      bus.start = 1'b0;
      bus.pause = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      chk("rst_flt_rst_n", bus.flt_rst_n, 1);
      chk("rst_flt_valid", bus.flt_valid, 0);
      chk("rst_flt_pixel", bus.flt_pixel, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_addr", bus.wr_addr, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      rst = 1'b0;
      step();

      // A: nominal frame, spurious filter outputs in IDLE and CLEAR
      rb = rd_addr_log.size(); wb = wr_addr_log.size();
      spur = 1'b1;
      repeat (3) step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("a_clr1_flt_rst_n", bus.flt_rst_n, 0);
      chk("a_clr1_busy", bus.busy, 1);
      chk("a_clr1_rd_en", bus.rd_en, 0);
      step();
      chk("a_clr2_flt_rst_n", bus.flt_rst_n, 0);
      step();
      spur = 1'b0;
      chk("a_feed_rd_en", bus.rd_en, 1);
      chk("a_feed_rd_addr", bus.rd_addr, 0);
      chk("a_feed_flt_rst_n", bus.flt_rst_n, 1);
      wait_done("a_done", 1);
      step();
      chk("a_busy_after", bus.busy, 0);
      chk("a_error", bus.error, 0);
      chk("a_done_once", done_cyc_log.size(), 1);
      chk("a_nrd", rd_addr_log.size() - rb, N);
      chk("a_nwr", wr_addr_log.size() - wb, OUTP);
      chk("a_rd_contig", rd_cyc_log[rb + N - 1] - rd_cyc_log[rb], N - 1);
      chk("a_wr_latency", wr_cyc_log[$] - vo_cyc_log[$], 1);
      check_frame("a", rb, wb, OUTP);

      // B: pause for 5 cycles after read address 10
      rb = rd_addr_log.size(); wb = wr_addr_log.size(); fb = fv_cyc_log.size();
      db = done_cyc_log.size();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      k = 0;
      while (!(bus.rd_en === 1'b1 && bus.rd_addr == 10) && k < 100) begin
         step();
         k++;
      end
      chk("b_saw_rd10", bus.rd_addr, 10);
      step();
      bus.pause = 1'b1;
      #1;
      chk("b_pause_rd_en", bus.rd_en, 0);
      step();
      chk("b_pause_flt_valid", bus.flt_valid, 0);
      repeat (4) step();
      bus.pause = 1'b0;
      wait_done("b_done", db + 1);
      step();
      chk("b_rd_gap", rd_cyc_log[rb + 11] - rd_cyc_log[rb + 10], 6);
      chk("b_fv_gap", fv_cyc_log[fb + 11] - fv_cyc_log[fb + 10], 6);
      chk("b_nrd", rd_addr_log.size() - rb, N);
      chk("b_nwr", wr_addr_log.size() - wb, OUTP);
      check_frame("b", rb, wb, OUTP);

      // C: start held high through a frame and past done
      rb = rd_addr_log.size(); wb = wr_addr_log.size();
      db = done_cyc_log.size(); clb = clr_low_n;
      bus.start = 1'b1;
      step();
      wait_done("c_done1", db + 1);
      chk("c_nrd1", rd_addr_log.size() - rb, N);
      repeat (2) step();
      bus.start = 1'b0;
      wait_done("c_done2", db + 2);
      step();
      chk("c_nrd2", rd_addr_log.size() - rb, 2 * N);
      chk("c_nwr", wr_addr_log.size() - wb, 2 * OUTP);
      chk("c_clear_cycles", clr_low_n - clb, 2 * CLR);
      check_frame("c1", rb, wb, OUTP);
      check_frame("c2", rb + N, wb + OUTP, OUTP);

      // D: reset at read address 30, then a clean frame
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      k = 0;
      while (!(bus.rd_en === 1'b1 && bus.rd_addr == 30) && k < 100) begin
         step();
         k++;
      end
      chk("d_saw_rd30", bus.rd_addr, 30);
      #2;
      rst = 1'b1;
      #1;
      chk("d_rst_busy", bus.busy, 0);
      chk("d_rst_rd_en", bus.rd_en, 0);
      chk("d_rst_rd_addr", bus.rd_addr, 0);
      chk("d_rst_flt_rst_n", bus.flt_rst_n, 1);
      chk("d_rst_flt_valid", bus.flt_valid, 0);
      chk("d_rst_wr_en", bus.wr_en, 0);
      chk("d_rst_wr_addr", bus.wr_addr, 0);
      wn = wr_addr_log.size();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) step();
      chk("d_no_wr_after_rst", wr_addr_log.size() - wn, 0);
      chk("d_idle_busy", bus.busy, 0);
      rb = rd_addr_log.size(); wb = wr_addr_log.size(); db = done_cyc_log.size();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done("d_done", db + 1);
      step();
      chk("d_nrd", rd_addr_log.size() - rb, N);
      chk("d_nwr", wr_addr_log.size() - wb, OUTP);
      check_frame("d", rb, wb, OUTP);

`ifdef SOBEL_SEQ_TIMEOUT_EN
      // E: filter stops after 20 outputs, drain watchdog ends the frame
      m_limit = 20;
      rb = rd_addr_log.size(); wb = wr_addr_log.size(); db = done_cyc_log.size();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_done("e_done", db + 1);
      chk("e_error", bus.error, 1);
      chk("e_nwr", wr_addr_log.size() - wb, 20);
      chk("e_last_wr_addr", wr_addr_log[$], 19);
      chk("e_timeout_cycles", done_cyc_log[$] - rd_cyc_log[$], DTO + 1);
      check_frame("e", rb, wb, 20);
      step();
      chk("e_error_sticky", bus.error, 1);
      m_limit = OUTP;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("e_error_cleared", bus.error, 0);
      wait_done("e2_done", db + 2);
      step();
      chk("e2_error", bus.error, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
